alu_iter_exec: RTL
==================

// Module: alu_iter_exec
// PURPOSE
//   Execute-side consumer of the 4-bit ALUControl code produced by the ALU decoder.
//   Accepts one operation per valid/ready handshake and returns the result on a
//   second valid/ready handshake.
//   Logic/arithmetic ops complete in 1 cycle. Shifts are iterative, 1 bit per cycle,
//   so no barrel shifter is needed.
//   Sits between the ID/EX register and EX/MEM of the multi-cycle execute option.
// PARAMETERS
//   WIDTH    32  operand/result width; must be a power of two >= 8
//   SHW      5   shift-amount width = log2(WIDTH); shift amount is src_b[SHW-1:0]
// PORTS
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous, active-low reset
//   in_valid     in   1      operation request valid
//   in_ready     out  1      block can accept a request (high only in IDLE)
//   alu_control  in   4      op code, captured on accept
//   src_a        in   WIDTH  operand A, captured on accept
//   src_b        in   WIDTH  operand B or shift amount, captured on accept
//   out_valid    out  1      result valid (high only in DONE)
//   out_ready    in   1      consumer accepts result
//   result       out  WIDTH  operation result
//   zero         out  1      result == 0
//   illegal      out  1      captured code not in the op table; qualified by out_valid
// BEHAVIOUR
//   Op table (alu_control):
//     0000 add   a+b, mod 2^WIDTH
//     0001 sub   a-b, mod 2^WIDTH
//     0010 and
//     0011 or
//     0100 xor
//     0101 slt   signed a<b, result {0..,1}
//     0110 srl   logical right shift
//     0111 sra   arithmetic right shift
//     1000 sll   left shift
//     1001 sltu  unsigned a<b
//     1010-1111  illegal: result=0, zero=1, illegal=1
//   Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0,
//     result=0, zero=1, illegal=0, shift counter=0.
//   States: IDLE, SHIFT, DONE.
//   IDLE: in_ready=1. Accept when in_valid is high.
//     - Non-shift or illegal op: compute and register result, go to DONE.
//       out_valid rises the cycle after accept (latency 1).
//     - Shift with amount n=0: result=src_a, go to DONE (latency 1).
//     - Shift with n>0: load src_a into the working register, count=n, go to SHIFT.
//   SHIFT: each cycle shift 1 bit (srl fills 0; sra fills the working MSB; sll fills 0 at LSB).
//     count is decremented each cycle; leave for DONE on the cycle count reaches 0.
//     Latency is n+1 cycles from accept to out_valid. in_ready=0.
//   DONE: out_valid=1. result, zero and illegal are held stable until out_ready=1.
//     On handshake go to IDLE. There is no accept in the same cycle, so the minimum
//     issue interval is 2 cycles.
//   Inputs are ignored when in_ready=0. in_valid may drop without penalty.
//   Only src_b[SHW-1:0] is used for shifts; upper bits are ignored.
//   reset_n low at any time (including mid-SHIFT or in DONE) aborts the operation
//   immediately and restores reset values. No partial result is emitted.
//   zero and illegal are registered together with result.
// TESTING
//   add 5,7 -> out_valid 1 cycle after accept, result=12, zero=0
//   sub 3,3 -> result=0, zero=1
//   sub 0,1 -> result=0xFFFFFFFF (wrap-around)
//   sra 0x80000000,4 -> SHIFT lasts 4 cycles, out_valid 5 cycles after accept,
//     result=0xF8000000
//   srl same operands -> result=0x08000000
//   sll 1, b=0x25 -> only low 5 bits used (shift by 5), result=0x20
//   sll with amount 0 -> result=src_a, latency 1
//   slt 0xFFFFFFFF,1 -> result=1
//   sltu 0xFFFFFFFF,1 -> result=0
//   illegal code 4'b1111 -> result=0, zero=1, illegal=1
//   hold out_ready=0 for 10 cycles -> result, zero, illegal stable and in_ready=0 throughout
//   assert reset_n mid-SHIFT -> out_valid=0 and in_ready=1 immediately
//   after reset, add 1,1 -> result=2

Source files
------------

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: execute-stage ALU driven by the 4-bit ALUControl code.
// Logic and arithmetic ops finish in one cycle. Shifts are iterative and
// move one bit per cycle, so the block needs no barrel shifter. Requests
// come in on a valid/ready handshake and results leave on a second one.
module alu_iter_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  state_t           state_r, state_nxt;
  logic [WIDTH-1:0] work_r, work_nxt;
  logic [SHW-1:0]   count_r, count_nxt;
  logic [3:0]       op_r, op_nxt;
  logic             illegal_r, illegal_nxt;
  logic             zero_r, zero_nxt;
  logic             in_ready_r, in_ready_nxt;
  logic             out_valid_r, out_valid_nxt;

  function automatic logic is_shift(input logic [3:0] op);
    case (op)
      OP_SRL, OP_SRA, OP_SLL: is_shift = 1'b1;
      default:                is_shift = 1'b0;
    endcase
  endfunction

  // Single-cycle ops; codes outside the table produce zero.
  function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  alu_compute = a + b;
      OP_SUB:  alu_compute = a - b;
      OP_AND:  alu_compute = a & b;
      OP_OR:   alu_compute = a | b;
      OP_XOR:  alu_compute = a ^ b;
      OP_SLT:  alu_compute = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_compute = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_compute = {WIDTH{1'b0}};
    endcase
  endfunction

  // One bit of shift for the captured shift kind.
  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] w);
    case (op)
      OP_SRL:  shift_step = {1'b0, w[WIDTH-1:1]};
      OP_SRA:  shift_step = {w[WIDTH-1], w[WIDTH-1:1]};
      OP_SLL:  shift_step = {w[WIDTH-2:0], 1'b0};
      default: shift_step = w;
    endcase
  endfunction

  // Next-state and datapath: the working register doubles as the result.
  always_comb begin
    state_nxt   = state_r;
    work_nxt    = work_r;
    count_nxt   = count_r;
    op_nxt      = op_r;
    illegal_nxt = illegal_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          op_nxt = alu_control;
          if (is_shift(alu_control)) begin
            illegal_nxt = 1'b0;
            work_nxt    = src_a;
            if (src_b[SHW-1:0] == {SHW{1'b0}}) begin
              state_nxt = S_DONE;
            end else begin
              count_nxt = src_b[SHW-1:0];
              state_nxt = S_SHIFT;
            end
          end else begin
            work_nxt    = alu_compute(alu_control, src_a, src_b);
            illegal_nxt = (alu_control >= 4'd10);
            state_nxt   = S_DONE;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_nxt  = shift_step(op_r, work_r);
        count_nxt = count_r - SHW'(1);
        if (count_r == SHW'(1)) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    zero_nxt      = (work_nxt == {WIDTH{1'b0}});
    in_ready_nxt  = (state_nxt == S_IDLE);
    out_valid_nxt = (state_nxt == S_DONE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      work_r      <= {WIDTH{1'b0}};
      count_r     <= {SHW{1'b0}};
      op_r        <= 4'd0;
      illegal_r   <= 1'b0;
      zero_r      <= 1'b1;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      work_r      <= work_nxt;
      count_r     <= count_nxt;
      op_r        <= op_nxt;
      illegal_r   <= illegal_nxt;
      zero_r      <= zero_nxt;
      in_ready_r  <= in_ready_nxt;
      out_valid_r <= out_valid_nxt;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = work_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;

endmodule
